// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the processor tick scheduler.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  localparam logic [31:0] DEFAULT_DIV = 32'h00FF_FFFF;

endpackage

// File: rtl/tick_scheduler_step_sync.sv
// Push-button synchronizer: two metastability flops plus an edge flop,
// producing a one-cycle pulse on each synchronized rising edge.
module step_sync (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_out
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_out = s2 & ~s3;

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler: programmable divider and mode FSM gating the processor
// step-enable (halt, free-run, N-tick burst, single manual step).
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | halted, divider held at 0, new divide value applied at once
//   ST_RUN   | free-running, one tick per div_active+1 cycles
//   ST_BURST | ticking until 'remaining' reaches 0
//   ST_STEP  | single-cycle manual step, tick_out high
module tick_scheduler #(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(tick_sched_pkg::DEFAULT_DIV),
  parameter int unsigned      BURST_W     = 8
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               step_btn,
  output logic               tick_out,
  output logic               busy,
  output logic [CNT_W-1:0]   div_active
);

  import tick_sched_pkg::*;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   div_pending;
  logic [BURST_W-1:0] remaining;
  logic               step_rise;
  logic               terminal;
  logic [CNT_W-1:0]   div_next;
  logic               burst_abort;

  step_sync u_step_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .async_in (step_btn),
    .rise_out (step_rise)
  );

  assign terminal    = (cnt == div_active);
  // A write landing on the terminal edge takes effect for the very next period.
  assign div_next    = cfg_we ? cfg_div : div_pending;
  assign burst_abort = (mode != MODE_BURST) && (mode != MODE_RUN);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      div_active  <= DEFAULT_DIV;
      div_pending <= DEFAULT_DIV;
      remaining   <= '0;
      tick_out    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (cfg_we) div_pending <= cfg_div;
      tick_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt        <= '0;
          div_active <= div_next;
          if (mode == MODE_RUN) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end else if (start && (mode == MODE_BURST) && (burst_len != '0)) begin
            state     <= ST_BURST;
            busy      <= 1'b1;
            remaining <= burst_len;
          end else if (step_rise) begin
            state    <= ST_STEP;
            busy     <= 1'b1;
            tick_out <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_RUN: begin
          if (mode != MODE_RUN) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (terminal) begin
            cnt        <= '0;
            tick_out   <= 1'b1;
            div_active <= div_next;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_BURST: begin
          if (burst_abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            remaining <= '0;
          end else if (terminal) begin
            cnt        <= '0;
            tick_out   <= 1'b1;
            div_active <= div_next;
            remaining  <= remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STEP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
